// File: rtl/seg7_scan4_if.sv
// seg7_scan4_if -- bus between a display client and the seg7_scan4 scanner.
//
// Handshake: load is a one-cycle strobe with no backpressure. value and
// dp_in are sampled on the same edge that sees load=1. The scanner never
// stalls the client. blank_all is a level control.
//
// Signals:
//   value[15:0]        four hex digits, [3:0] = rightmost digit (digit 0)
//   load               capture strobe for value/dp_in
//   dp_in[3:0]         per-digit decimal point request
//   blank_all          force display dark (scanning continues)
//   an[3:0]            digit enables (registered)
//   seg7[6:0]          segments {g,f,e,d,c,b,a} (registered)
//   dp                 decimal point of the active digit (registered)
//   frame_tick         one-cycle pulse when a pending value is committed
//   dbg_digit_sel[1:0] current scan slot, for checkers
interface seg7_scan4_if;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_in;
  logic        blank_all;
  logic [3:0]  an;
  logic [6:0]  seg7;
  logic        dp;
  logic        frame_tick;
  logic [1:0]  dbg_digit_sel;

  modport master (
    output value, load, dp_in, blank_all,
    input  an, seg7, dp, frame_tick, dbg_digit_sel
  );

  modport slave (
    input  value, load, dp_in, blank_all,
    output an, seg7, dp, frame_tick, dbg_digit_sel
  );
endinterface

// File: rtl/seg7_scan4.sv
// seg7_scan4 -- time-multiplexed driver for a 4-digit common-anode
// 7-segment display.
//
// Keeps a pending register for client loads and an active register that is
// only updated at the frame boundary (end of digit 3's slot), so a frame is
// never drawn with a mix of old and new digits. Each digit slot lasts
// REFRESH_DIV cycles; the first cycle after a slot change is dark to avoid
// ghosting.
//
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   seg7_scan4_if.slave (value/load/dp_in/blank_all in,
//         an/seg7/dp/frame_tick/dbg_digit_sel out)
//
// Parameters:
//   REFRESH_DIV     clk cycles per digit slot (>= 2)
//   SEG_ACTIVE_LOW  1 = seg7/dp low-true
//   AN_ACTIVE_LOW   1 = an low-true
//
// Build option: define SEG7_SCAN_LZB_EN to blank leading zero digits
// (digits 3..1); a digit whose dp is set ends the run of blanked zeros.
module seg7_scan4 #(
  parameter int REFRESH_DIV    = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input logic          clk,
  input logic          rst,
  seg7_scan4_if.slave  bus
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [3:0] AN_OFF  = (AN_ACTIVE_LOW  != 0) ? 4'hF  : 4'h0;
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    digit_q, digit_d;
  logic [19:0]   pending_q, pending_d;    // {dp[3:0], value[15:0]}
  logic          pend_valid_q, pend_valid_d;
  logic [19:0]   active_q, active_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_tick_q, frame_tick_d;

  logic          tick, boundary, suppress, lit;
  logic [3:0]    nibble;
  logic [3:0]    act_dp;
  logic [3:0]    an_raw;
  logic [6:0]    seg_raw;
  logic          dp_raw;
`ifdef SEG7_SCAN_LZB_EN
  logic          lz_run;
  logic [3:0]    lz_mask;
`endif

  always_comb begin
    tick     = (presc_q == PRESC_LAST);
    boundary = tick && (digit_q == 2'd3);
    presc_d  = tick ? '0 : presc_q + PW'(1);
    digit_d  = tick ? digit_q + 2'd1 : digit_q;

    pending_d    = pending_q;
    pend_valid_d = pend_valid_q;
    active_d     = active_q;
    frame_tick_d = 1'b0;

    if (bus.load) begin
      pending_d    = {bus.dp_in, bus.value};
      pend_valid_d = 1'b1;
    end

    // A load on the boundary cycle is newer than anything pending, so it
    // bypasses the pending register and commits directly.
    if (boundary) begin
      if (bus.load) begin
        active_d     = {bus.dp_in, bus.value};
        pend_valid_d = 1'b0;
        frame_tick_d = 1'b1;
      end else if (pend_valid_q) begin
        active_d     = pending_q;
        pend_valid_d = 1'b0;
        frame_tick_d = 1'b1;
      end
    end

    nibble = active_q[{digit_q, 2'b00} +: 4];
    act_dp = active_q[19:16];

`ifdef SEG7_SCAN_LZB_EN
    // Walk from the most significant digit down; the run of blanked digits
    // stops at the first non-zero nibble or set decimal point.
    lz_run  = 1'b1;
    lz_mask = 4'b0000;
    for (int i = 3; i >= 1; i--) begin
      lz_run     = lz_run & (active_q[4*i +: 4] == 4'h0) & ~act_dp[i];
      lz_mask[i] = lz_run;
    end
    suppress = lz_mask[digit_q];
`else
    suppress = 1'b0;
`endif

    // The tick edge is the anti-ghosting gap: the outgoing digit is dark
    // while digit_sel moves on.
    lit     = !tick && !bus.blank_all && !suppress;
    an_raw  = lit ? (4'b0001 << digit_q) : 4'b0000;
    seg_raw = lit ? hex_to_seg(nibble) : 7'h00;
    dp_raw  = lit && act_dp[digit_q];

    an_d  = (AN_ACTIVE_LOW  != 0) ? ~an_raw  : an_raw;
    seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    dp_d  = (SEG_ACTIVE_LOW != 0) ? ~dp_raw  : dp_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      digit_q      <= 2'd0;
      pending_q    <= '0;
      pend_valid_q <= 1'b0;
      active_q     <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      digit_q      <= digit_d;
      pending_q    <= pending_d;
      pend_valid_q <= pend_valid_d;
      active_q     <= active_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.an            = an_q;
  assign bus.seg7          = seg_q;
  assign bus.dp            = dp_q;
  assign bus.frame_tick    = frame_tick_q;
  assign bus.dbg_digit_sel = digit_q;

endmodule

// File: tb/tb_seg7_scan4.sv
// tb_seg7_scan4 -- directed bench for seg7_scan4 (REFRESH_DIV=4, active-low
// segments and anodes). Each driven cycle pushes the expected registered
// outputs {chk, an, seg7, dp, frame_tick} into exp_q; a monitor pops one
// entry per clock and compares.
module tb_seg7_scan4;

  localparam int W = 14;

`ifdef SEG7_SCAN_LZB_EN
  localparam logic LZB = 1'b1;
`else
  localparam logic LZB = 1'b0;
`endif
  // Digits expected dark for an all-zero value / for value 16'h0050.
  localparam logic [3:0] ZD   = LZB ? 4'b1110 : 4'b0000;
  localparam logic [3:0] ZD50 = LZB ? 4'b1100 : 4'b0000;

  logic clk;
  logic rst;
  seg7_scan4_if bus ();

  seg7_scan4 #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  string        tag;
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;

  initial begin
    logic [W-1:0]  e;
    logic [W-2:0]  got;
    string         t;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (e[W-1]) begin
          n_tests++;
          got = {bus.an, bus.seg7, bus.dp, bus.frame_tick};
          if (got !== e[W-2:0]) begin
            n_fail++;
            $display("FAIL %s cyc%0d: got an=%b seg7=%h dp=%b ft=%b, expected an=%b seg7=%h dp=%b ft=%b",
                     t, cyc, bus.an, bus.seg7, bus.dp, bus.frame_tick,
                     e[12:9], e[8:2], e[1], e[0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic r, input logic ld, input logic [15:0] v,
                      input logic [3:0] dpi, input logic bl,
                      input logic [3:0] ean, input logic [6:0] eseg,
                      input logic edp, input logic eft);
    rst           = r;
    bus.load      = ld;
    bus.blank_all = bl;
    if (ld) begin
      bus.value = v;
      bus.dp_in = dpi;
    end
    exp_q.push_back({1'b1, ean, eseg, edp, eft});
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
  endtask

  // One digit slot (4 cycles). seg/dpo are the active-low values while lit;
  // bl drives blank_all per cycle; ld_j selects the cycle carrying a load.
  task automatic slot(input int d, input logic [6:0] seg, input logic dpo,
                      input logic ft3, input logic [3:0] bl, input logic dark,
                      input int ld_j, input logic [15:0] v, input logic [3:0] dpi);
    logic       lit;
    logic [3:0] an_on;
    an_on = ~(4'b0001 << d);
    for (int j = 0; j < 4; j++) begin
      lit = (j < 3) && !bl[j] && !dark;
      step(1'b0, (j == ld_j), v, dpi, bl[j],
           lit ? an_on : 4'hF, lit ? seg : 7'h7F, lit ? dpo : 1'b1,
           (j == 3) ? ft3 : 1'b0);
    end
  endtask

  task automatic frame(input logic [27:0] segs, input logic [3:0] dpo,
                       input logic ft, input logic [3:0] dark);
    for (int d = 0; d < 4; d++)
      slot(d, segs[d*7 +: 7], dpo[d], (d == 3) ? ft : 1'b0, 4'b0000, dark[d],
           -1, 16'h0000, 4'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.value     = 16'h0000;
    bus.dp_in     = 4'h0;
    bus.load      = 1'b0;
    bus.blank_all = 1'b0;
    rst           = 1'b1;

    tag = "reset";
    step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 4'hF, 7'h7F, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 4'hF, 7'h7F, 1'b1, 1'b0);

    tag = "scan_zero";
    frame({4{7'h40}}, 4'hF, 1'b0, ZD);

    tag = "load_mid";
    slot(0, 7'h40, 1'b1, 1'b0, 4'b0000, ZD[0], -1, 16'h0, 4'h0);
    slot(1, 7'h40, 1'b1, 1'b0, 4'b0000, ZD[1],  1, 16'h12AF, 4'h0);
    slot(2, 7'h40, 1'b1, 1'b0, 4'b0000, ZD[2], -1, 16'h0, 4'h0);
    slot(3, 7'h40, 1'b1, 1'b1, 4'b0000, ZD[3], -1, 16'h0, 4'h0);

    tag = "show_12af";
    slot(0, 7'h0E, 1'b1, 1'b0, 4'b0000, 1'b0,  1, 16'h1111, 4'h0);
    slot(1, 7'h08, 1'b1, 1'b0, 4'b0000, 1'b0, -1, 16'h0, 4'h0);
    slot(2, 7'h24, 1'b1, 1'b0, 4'b0000, 1'b0,  0, 16'h2222, 4'h0);
    slot(3, 7'h79, 1'b1, 1'b1, 4'b0000, 1'b0, -1, 16'h0, 4'h0);

    tag = "show_2222";
    slot(0, 7'h24, 1'b1, 1'b0, 4'b0000, 1'b0, -1, 16'h0, 4'h0);
    slot(1, 7'h24, 1'b1, 1'b0, 4'b0000, 1'b0, -1, 16'h0, 4'h0);
    slot(2, 7'h24, 1'b1, 1'b0, 4'b0000, 1'b0, -1, 16'h0, 4'h0);
    slot(3, 7'h24, 1'b1, 1'b1, 4'b0000, 1'b0,  3, 16'h3333, 4'b0101);

    tag = "show_3333";
    frame({4{7'h30}}, 4'b1010, 1'b0, 4'b0000);

    tag = "blank";
    slot(0, 7'h30, 1'b0, 1'b0, 4'b0000, 1'b0, -1, 16'h0, 4'h0);
    slot(1, 7'h30, 1'b1, 1'b0, 4'b0000, 1'b0, -1, 16'h0, 4'h0);
    slot(2, 7'h30, 1'b0, 1'b0, 4'b1110, 1'b0, -1, 16'h0, 4'h0);
    slot(3, 7'h30, 1'b1, 1'b1, 4'b1111, 1'b0,  0, 16'h0050, 4'h0);
    slot(0, 7'h40, 1'b1, 1'b0, 4'b0111, 1'b0, -1, 16'h0, 4'h0);

    tag = "show_0050";
    slot(1, 7'h12, 1'b1, 1'b0, 4'b0000, 1'b0, -1, 16'h0, 4'h0);
    slot(2, 7'h40, 1'b1, 1'b0, 4'b0000, ZD50[2], -1, 16'h0, 4'h0);
    slot(3, 7'h40, 1'b1, 1'b0, 4'b0000, ZD50[3], -1, 16'h0, 4'h0);

    tag = "rst_mid";
    slot(0, 7'h40, 1'b1, 1'b0, 4'b0000, 1'b0, -1, 16'h0, 4'h0);
    slot(1, 7'h12, 1'b1, 1'b0, 4'b0000, 1'b0,  0, 16'h1234, 4'hF);
    step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0,
         ZD50[2] ? 4'hF : 4'b1011, ZD50[2] ? 7'h7F : 7'h40, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 4'hF, 7'h7F, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 4'hF, 7'h7F, 1'b1, 1'b0);

    tag = "after_rst";
    frame({4{7'h40}}, 4'hF, 1'b0, ZD);
    frame({4{7'h40}}, 4'hF, 1'b0, ZD);

`ifdef SEG7_SCAN_LZB_EN
    tag = "lzb_load";
    slot(0, 7'h40, 1'b1, 1'b0, 4'b0000, 1'b0,  1, 16'h0050, 4'b1000);
    slot(1, 7'h40, 1'b1, 1'b0, 4'b0000, 1'b1, -1, 16'h0, 4'h0);
    slot(2, 7'h40, 1'b1, 1'b0, 4'b0000, 1'b1, -1, 16'h0, 4'h0);
    slot(3, 7'h40, 1'b1, 1'b1, 4'b0000, 1'b1, -1, 16'h0, 4'h0);

    tag = "lzb_dp";
    slot(0, 7'h40, 1'b1, 1'b0, 4'b0000, 1'b0, -1, 16'h0, 4'h0);
    slot(1, 7'h12, 1'b1, 1'b0, 4'b0000, 1'b0, -1, 16'h0, 4'h0);
    slot(2, 7'h40, 1'b1, 1'b0, 4'b0000, 1'b0, -1, 16'h0, 4'h0);
    slot(3, 7'h40, 1'b0, 1'b1, 4'b0000, 1'b0,  0, 16'h0000, 4'h0);

    tag = "lzb_zero";
    frame({4{7'h40}}, 4'hF, 1'b0, 4'b1110);
`endif

    repeat (2) @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan4.md
Name: seg7_scan4

Overview:
- Downstream display stage for the counter/decoder path: drives a 4-digit common-anode 7-segment display by time-multiplexing one digit at a time.
- Holds a tear-free shadow of a 16-bit value (4 hex nibbles), decodes each nibble to segments internally, and rotates the digit enables at a programmable refresh rate.
- Replaces direct single-digit drive when the board's multi-digit display is used.

Parameters:
- REFRESH_DIV, 4, clk cycles per digit slot; minimum 2. Board build uses 100000.
- SEG_ACTIVE_LOW, 1, 1 = seg7/dp driven low-true; 0 = high-true.
- AN_ACTIVE_LOW, 1, 1 = an[] low-true; 0 = high-true.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- value  in  16  four hex digits; [3:0] is the rightmost digit (digit 0)
- load  in  1  1-cycle strobe: capture value/dp_in into the pending register
- dp_in  in  4  per-digit decimal point request, bit i = digit i
- blank_all  in  1  force display dark; scanning continues
- an  out  4  digit enables, one-hot when active
- seg7  out  7  segments {g,f,e,d,c,b,a}, seg7[0]=a
- dp  out  1  decimal point for the active digit
- frame_tick  out  1  1-cycle pulse when a pending value is committed

Behaviour:
- All outputs are registered.
- Reset (rst=1 at an edge):
  - prescaler=0, digit_sel=0, pending=0, pend_valid=0, active=0.
  - an=all inactive, seg7=all off, dp=off, frame_tick=0.
  - Reset mid-scan aborts the slot immediately and drops any pending load.
- First edge with rst=0: an selects digit 0, seg7 shows "0" (active-high 7'h3F; active-low 7'h40).
- Prescaler counts 0..REFRESH_DIV-1 and wraps. A tick occurs when prescaler==REFRESH_DIV-1.
- On a tick, digit_sel advances 0->1->2->3->0.
- Anti-ghosting: on the edge that consumes a tick, an=all inactive for exactly 1 cycle. Next edge: new digit enabled with its segments. Each digit is therefore lit REFRESH_DIV-1 of every REFRESH_DIV cycles.
- Load: when load=1, pending<={dp_in,value} and pend_valid<=1. The last load before commit wins.
- Commit at the frame boundary (tick with digit_sel==3):
  - If pend_valid=1: active<=pending, pend_valid<=0, frame_tick=1 for the next cycle.
  - If load=1 on the boundary cycle: that cycle's value/dp_in commits directly (bypass), pend_valid ends 0, frame_tick=1.
  - No commit: frame_tick stays 0 and active is unchanged.
- Decode, active-high gfedcba patterns; SEG_ACTIVE_LOW inverts:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- dp is on iff active dp bit[digit_sel]=1.
- blank_all=1: from the next edge, an all inactive, seg7/dp off. Prescaler, digit_sel and commit logic continue. On release, the display resumes at the current digit_sel on the next edge.

Optional Feature:
- Macro: SEG7_SCAN_LZB_EN (leading-zero blanking).
- Defined: digit i (i=3..1) is blanked in its slot (an inactive, seg7 off, dp off) when active nibble i and every higher nibble are 0. A digit with its dp bit set is never blanked. Digit 0 is always shown. Timing is unchanged.
- Undefined: all four digits are always shown, including leading zeros.

Test Plan:
- Reset then release, REFRESH_DIV=4 -> an=1110, seg7=7'h40 on the first cycle; an=1111 on the tick edge; then an=1101, 1011, 0111, 1110 in turn.
- load with value=16'h12AF mid-frame -> no display change until the 3->0 boundary; frame_tick=1 for one cycle; digits 0..3 then show F(0E), A(08), 2(24), 1(79) active-low.
- Two loads before the boundary (16'h1111, then 16'h2222) -> only 2222 is committed. A load on the boundary cycle itself (16'h3333) -> commits that cycle, frame_tick=1, no pending leftover.
- blank_all held for 10 cycles mid-digit-2 -> an=1111 throughout; scanning keeps advancing, so after release the enabled digit matches the tick count.
- rst asserted while pend_valid=1 and digit_sel=2 -> next cycle all outputs dark/zero; after release digit 0 shows "0"; the old pending value is never displayed.
- SEG7_SCAN_LZB_EN defined, value=16'h0050, dp_in=4'b1000 -> digit 3 shown as "0" with dp; digit 2 shows 0; digit 1 shows 5; digit 0 shows 0. With value=16'h0000, dp_in=0 -> only digit 0 is lit.
